button_debouncer: RTL and testbench



---
 rtl/button_debouncer.sv | 114 +++++++++++
 tb/tb_button_debouncer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchronize, debounce and edge-detect the five push buttons
// Optional auto-repeat of btn_press is enabled by defining BUTTON_AUTOREPEAT_EN.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       BTNC,
  input  logic       BTNU,
  input  logic       BTND,
  input  logic       BTNL,
  input  logic       BTNR,
  output logic [4:0] btn_db,
  output logic [4:0] btn_press,
  output logic       multi
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [4:0]    raw;
  logic [4:0]    s1_q, s2_q;
  logic [4:0]    db_q, db_d;
  logic [4:0]    press_q, press_d;
  logic [4:0]    rpt_d;
  logic          multi_q, multi_d;
  logic [CW-1:0] cnt_q [5];
  logic [CW-1:0] cnt_d [5];
  logic [2:0]    pop;

  assign raw = {BTNC, BTNU, BTND, BTNL, BTNR};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      db_q    <= '0;
      press_q <= '0;
      multi_q <= 1'b0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      db_q    <= db_d;
      press_q <= press_d;
      multi_q <= multi_d;
      for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // The counter only runs while s2 disagrees with the accepted level.
  always_comb begin
    db_d = db_q;
    pop  = '0;
    for (int i = 0; i < 5; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
      pop = pop + {2'b00, db_d[i]};
    end
    press_d = (db_d & ~db_q) | rpt_d;
    multi_d = (pop >= 3'd2);
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rcnt_q [5];
  logic [RW-1:0] rcnt_d [5];
  logic [4:0]    first_q, first_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q <= '0;
      for (int i = 0; i < 5; i++) rcnt_q[i] <= '0;
    end else begin
      first_q <= first_d;
      for (int i = 0; i < 5; i++) rcnt_q[i] <= rcnt_d[i];
    end
  end

  // first_q selects the long initial delay until the first repeat has fired.
  always_comb begin
    rpt_d   = '0;
    first_d = first_q;
    for (int i = 0; i < 5; i++) begin
      rcnt_d[i] = '0;
      if (!db_d[i] || !db_q[i]) begin
        first_d[i] = 1'b1;
      end else if (rcnt_q[i] == RW'(first_q[i] ? REPEAT_DELAY - 1 : REPEAT_PERIOD - 1)) begin
        rpt_d[i]   = 1'b1;
        first_d[i] = 1'b0;
      end else begin
        rcnt_d[i] = rcnt_q[i] + RW'(1);
      end
    end
  end
`else
  assign rpt_d = '0;
`endif

  assign btn_db    = db_q;
  assign btn_press = press_q;
  assign multi     = multi_q;

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - directed self-checking bench for button_debouncer
module tb_button_debouncer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       BTNC, BTNU, BTND, BTNL, BTNR;
  logic [4:0] btn_db, btn_press;
  logic       multi;

  int passes = 0;
  int total  = 0;

  button_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .BTNC     (BTNC),
    .BTNU     (BTNU),
    .BTND     (BTND),
    .BTNL     (BTNL),
    .BTNR     (BTNR),
    .btn_db   (btn_db),
    .btn_press(btn_press),
    .multi    (multi)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic [4:0] db, input logic [4:0] pr, input logic m);
    chk({tag, ".db"}, {27'd0, btn_db}, {27'd0, db});
    chk({tag, ".press"}, {27'd0, btn_press}, {27'd0, pr});
    chk({tag, ".multi"}, {31'd0, multi}, {31'd0, m});
  endtask

  initial begin
    int pulses;
    logic exp_p;

    // reset held with every button pressed
    rst_n = 1'b0;
    {BTNC, BTNU, BTND, BTNL, BTNR} = 5'b11111;
    tick(1);
    chk_all("rst_hold0", 5'b00000, 5'b00000, 1'b0);
    tick(4);
    chk_all("rst_hold1", 5'b00000, 5'b00000, 1'b0);
    rst_n = 1'b1;
    tick(5);
    chk_all("rst_rel5", 5'b00000, 5'b00000, 1'b0);
    tick(1);
    chk_all("rst_rel6", 5'b11111, 5'b11111, 1'b1);
    tick(1);
    chk_all("rst_rel7", 5'b11111, 5'b00000, 1'b1);

    // release all: falling edges give no pulse
    {BTNC, BTNU, BTND, BTNL, BTNR} = 5'b00000;
    tick(5);
    chk_all("relall5", 5'b11111, 5'b00000, 1'b1);
    tick(1);
    chk_all("relall6", 5'b00000, 5'b00000, 1'b0);

    // clean press on BTNU
    BTNU = 1'b1;
    tick(5);
    chk_all("up_pre", 5'b00000, 5'b00000, 1'b0);
    tick(1);
    chk_all("up_rise", 5'b01000, 5'b01000, 1'b0);
    tick(1);
    chk_all("up_after", 5'b01000, 5'b00000, 1'b0);
    tick(13);
    BTNU = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      chk_all("up_fall_wait", 5'b01000, 5'b00000, 1'b0);
    end
    tick(1);
    chk_all("up_fall", 5'b00000, 5'b00000, 1'b0);
    tick(2);
    chk_all("up_idle", 5'b00000, 5'b00000, 1'b0);

    // bouncing BTNL: two high, two low, three times, then held high
    for (int i = 0; i < 12; i++) begin
      BTNL = ((i % 4) < 2);
      tick(1);
      chk("bounce_db", {31'd0, btn_db[1]}, 32'd0);
    end
    BTNL   = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (btn_press[1]) pulses++;
      if (i == 5) chk("bounce_pre", {27'd0, btn_db}, 32'd0);
      if (i == 6) chk_all("bounce_rise", 5'b00010, 5'b00010, 1'b0);
    end
    chk("bounce_pulses", pulses, 32'd1);
    BTNL = 1'b0;
    tick(6);
    chk_all("bounce_rel", 5'b00000, 5'b00000, 1'b0);

    // short glitch on BTNR
    BTNR = 1'b1;
    tick(3);
    BTNR = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk("glitch_db", {31'd0, btn_db[0]}, 32'd0);
      chk("glitch_press", {31'd0, btn_press[0]}, 32'd0);
    end

    // simultaneous BTNC and BTND
    BTNC = 1'b1;
    BTND = 1'b1;
    tick(6);
    chk_all("sim_rise", 5'b10100, 5'b10100, 1'b1);
    tick(1);
    chk_all("sim_hold", 5'b10100, 5'b00000, 1'b1);
    BTNC = 1'b0;
    tick(5);
    chk_all("sim_c_pre", 5'b10100, 5'b00000, 1'b1);
    tick(1);
    chk_all("sim_c_rel", 5'b00100, 5'b00000, 1'b0);
    BTND = 1'b0;
    tick(6);
    chk_all("sim_d_rel", 5'b00000, 5'b00000, 1'b0);

    // reset in the middle of a count
    BTNC = 1'b1;
    tick(3);
    rst_n = 1'b0;
    tick(1);
    chk_all("mid_rst", 5'b00000, 5'b00000, 1'b0);
    rst_n = 1'b1;
    tick(5);
    chk_all("mid_rel5", 5'b00000, 5'b00000, 1'b0);
    tick(1);
    chk_all("mid_rel6", 5'b10000, 5'b10000, 1'b0);
    BTNC = 1'b0;
    tick(6);
    chk_all("mid_done", 5'b00000, 5'b00000, 1'b0);

    // long hold on BTNU: single pulse, or repeats when auto-repeat is built in
    BTNU = 1'b1;
    for (int i = 1; i <= 75; i++) begin
      if (i == 61) BTNU = 1'b0;
      tick(1);
`ifdef BUTTON_AUTOREPEAT_EN
      exp_p = (i == 6) || (i == 26) || (i == 34) || (i == 42) || (i == 50) || (i == 58);
`else
      exp_p = (i == 6);
`endif
      chk("hold_press", {27'd0, btn_press}, {27'd0, exp_p, 3'b000});
    end
    chk_all("hold_end", 5'b00000, 5'b00000, 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
